// File: rtl/ahb_master_port.sv
// ahb_master_port
//   Master-side AHB-Lite port paired with the bus arbiter. Accepts one
//   read/write command from a local client, requests the bus with a 2-bit
//   slave select, waits for the grant, runs a single NONSEQ transfer
//   (address phase then data phase) and returns read data / error status.
//   hreq stays high through the data phase because the arbiter releases the
//   grant only after it observes the completing hready.
//
// Ports
//   hclk, hresetn           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     client command handshake (ready only in IDLE)
//   cmd_write/sel/addr/wdata command fields, latched on acceptance
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               read data (0 for writes/timeouts), held to next rsp
//   rsp_err, rsp_timeout    slave ERROR or grant timeout; timeout flag
//   hreq, sel, hgrant       arbiter request / slave select / grant
//   haddr, hwrite, htrans, hwdata, hrdata, hready, hresp  AHB-Lite signals
module ahb_master_port #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              hreq,
    output logic [1:0]        sel,
    input  logic              hgrant,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam int CNT_W = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(GRANT_TIMEOUT - 1);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DATA} state_t;

    typedef struct packed {
        logic              write;
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    cmd_t              cmd_q;
    logic              cmd_ld;
    logic              rsp_valid_nxt, rsp_err_nxt, rsp_tmo_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cmd_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_tmo_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            if (cmd_ld) begin
                cmd_q <= '{write: cmd_write, sel: cmd_sel,
                           addr: cmd_addr, wdata: cmd_wdata};
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cmd_ld        = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_tmo_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (cmd_valid) begin
                    cmd_ld    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (hgrant) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LIM) begin
                    // Give up on the arbiter; report as an error with no data.
                    state_nxt     = S_IDLE;
                    cnt_nxt       = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_tmo_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_ADDR: begin
                // Losing the grant before the address is taken aborts the
                // phase; the request restarts with a fresh timeout window.
                if (!hgrant) begin
                    state_nxt = S_REQ;
                    cnt_nxt   = '0;
                end else if (hready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (hready) begin
                    state_nxt     = S_IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = hresp;
                    rsp_rdata_nxt = cmd_q.write ? '0 : hrdata;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus-side outputs decode only from registered state and command.
    assign cmd_ready = (state == S_IDLE);
    assign hreq      = (state != S_IDLE);
    assign sel       = hreq ? cmd_q.sel : 2'b00;
    assign htrans    = (state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = (state == S_ADDR) ? cmd_q.addr : '0;
    assign hwrite    = (state == S_ADDR) & cmd_q.write;
    assign hwdata    = ((state == S_DATA) && cmd_q.write) ? cmd_q.wdata : '0;

endmodule

// File: tb/tb_ahb_master_port.sv
// Bench for ahb_master_port: table of transfer vectors with scripted bus
// timing, expected responses queued at command issue and popped when
// rsp_valid appears, plus hand sequences for timeout, grant loss and reset.
module tb_ahb_master_port;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GT = 16;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0]    cmd_sel = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          hreq, hwrite, hgrant = 1'b0, hready = 1'b1, hresp = 1'b0;
    logic [1:0]    sel, htrans;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata, hrdata = '0;

    ahb_master_port #(.ADDR_W(AW), .DATA_W(DW), .GRANT_TIMEOUT(GT)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .hreq(hreq), .sel(sel), .hgrant(hgrant),
        .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          write;
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            g;      // REQ cycles before grant is visible
        int            aw;     // hready=0 cycles in address phase
        int            dw;     // hready=0 cycles in data phase
        logic          herr;   // hresp driven through the data phase
        logic [DW-1:0] hrd;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            at;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bus_idle();
        hgrant = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    endtask

    task automatic check_rsp();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected at cycle %0d", cyc);
        end else begin
            e = sb.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            chk("rsp_cycle", 64'(cyc), 64'(e.at));
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_sel = s; cmd_addr = a; cmd_wdata = d;
    endtask

    // Caller is at a negedge; returns at the negedge of the response cycle.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int a0, d0, r;
        bit got;
        a0 = v.g + 2;
        d0 = v.g + 3 + v.aw;
        r  = v.g + 4 + v.aw + v.dw;
        issue(v.write, v.sel, v.addr, v.wdata);
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.tmo = 1'b0; e.at = cyc + r;
        sb.push_back(e);
        got = 1'b0;
        for (int c = 1; c <= r + 8 && !got; c++) begin
            @(negedge hclk);
            cmd_valid = 1'b0;
            if (c < a0) begin
                chk("req_hreq", 64'(hreq), 64'd1);
                chk("req_sel", 64'(sel), 64'(v.sel));
                chk("req_htrans", 64'(htrans), 64'd0);
                chk("req_no_rsp", 64'(rsp_valid), 64'd0);
                hgrant = (c == v.g + 1); hready = 1'b1; hresp = 1'b0;
            end else if (c < d0) begin
                chk("addr_htrans", 64'(htrans), 64'h2);
                chk("addr_haddr", 64'(haddr), 64'(v.addr));
                chk("addr_hwrite", 64'(hwrite), 64'(v.write));
                hgrant = 1'b1; hready = (c == d0 - 1); hresp = 1'b0;
            end else if (c < r) begin
                chk("data_htrans", 64'(htrans), 64'd0);
                chk("data_hreq", 64'(hreq), 64'd1);
                chk("data_haddr", 64'(haddr), 64'd0);
                chk("data_hwdata", 64'(hwdata), v.write ? 64'(v.wdata) : 64'd0);
                hgrant = 1'b0; hready = (c == r - 1); hresp = v.herr; hrdata = v.hrd;
            end else begin
                bus_idle();
                if (rsp_valid) begin
                    chk("rsp_hreq_low", 64'(hreq), 64'd0);
                    chk("rsp_cmd_ready", 64'(cmd_ready), 64'd1);
                    check_rsp();
                    got = 1'b1;
                end
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_missing waited=%0d cycles want_at=%0d", r + 8, e.at);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1, 0, 0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 32'h40, 32'h0, 1, 0, 2, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        vecs[2] = '{1'b0, 2'd3, 32'h80, 32'h0, 1, 0, 1, 1'b1, 32'hAAAA5555, 32'hAAAA5555, 1'b1};
        vecs[3] = '{1'b1, 2'd0, 32'h200, 32'h0F0F0F0F, 3, 2, 1, 1'b0, 32'h77777777, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 2'd2, 32'hFFFFFFFC, 32'h0, 2, 1, 0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 32'h4, 32'h1, 1, 0, 1, 1'b1, 32'h99999999, 32'h0, 1'b1};

        // Reset state
        repeat (2) @(negedge hclk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_hreq", 64'(hreq), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_hwdata", 64'(hwdata), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        hresetn = 1'b1;
        @(negedge hclk);

        // Table vectors, issued back-to-back in each response cycle
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Grant timeout: response GT cycles after REQ entry
        issue(1'b0, 2'd3, 32'h300, 32'h0);
        e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.at = cyc + GT + 1;
        sb.push_back(e);
        for (int c = 1; c <= GT + 1; c++) begin
            @(negedge hclk);
            cmd_valid = 1'b0;
            bus_idle();
            if (c <= GT) begin
                chk("tmo_hreq", 64'(hreq), 64'd1);
                chk("tmo_no_early", 64'(rsp_valid), 64'd0);
            end else begin
                chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
                chk("tmo_hreq_low", 64'(hreq), 64'd0);
                if (rsp_valid) check_rsp();
                else void'(sb.pop_front());
            end
        end
        @(negedge hclk);
        chk("tmo_pulse_one", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        chk("tmo_hreq_after", 64'(hreq), 64'd0);

        // Grant dropped during a stalled address phase
        issue(1'b0, 2'd1, 32'h500, 32'h0);
        e.rdata = 32'h0BADCAFE; e.err = 1'b0; e.tmo = 1'b0; e.at = cyc + 9;
        sb.push_back(e);
        for (int c = 1; c <= 9; c++) begin
            @(negedge hclk);
            cmd_valid = 1'b0;
            bus_idle();
            case (c)
                2: hgrant = 1'b1;
                3: begin
                    chk("gd_addr1_htrans", 64'(htrans), 64'h2);
                    chk("gd_addr1_haddr", 64'(haddr), 64'h500);
                    hgrant = 1'b1; hready = 1'b0;
                end
                4: begin
                    chk("gd_stall_htrans", 64'(htrans), 64'h2);
                    hgrant = 1'b0; hready = 1'b0;
                end
                5: begin
                    chk("gd_req_htrans", 64'(htrans), 64'd0);
                    chk("gd_req_hreq", 64'(hreq), 64'd1);
                    chk("gd_req_haddr", 64'(haddr), 64'd0);
                end
                6: hgrant = 1'b1;
                7: begin
                    chk("gd_addr2_haddr", 64'(haddr), 64'h500);
                    chk("gd_addr2_htrans", 64'(htrans), 64'h2);
                    hgrant = 1'b1;
                end
                8: begin
                    chk("gd_data_hreq", 64'(hreq), 64'd1);
                    hrdata = 32'h0BADCAFE;
                end
                9: begin
                    chk("gd_rsp_valid", 64'(rsp_valid), 64'd1);
                    if (rsp_valid) check_rsp();
                    else void'(sb.pop_front());
                end
                default: ;
            endcase
        end

        // Reset asserted during the data phase drops the command
        issue(1'b1, 2'd2, 32'h600, 32'h55AA55AA);
        @(negedge hclk); cmd_valid = 1'b0; bus_idle();
        @(negedge hclk); hgrant = 1'b1;
        @(negedge hclk); hgrant = 1'b1; hready = 1'b1;
        @(negedge hclk); hgrant = 1'b0; hready = 1'b0;
        chk("rd_data_hwdata", 64'(hwdata), 64'h55AA55AA);
        hresetn = 1'b0;
        #1;
        chk("rd_hreq", 64'(hreq), 64'd0);
        chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rd_hwdata", 64'(hwdata), 64'd0);
        chk("rd_sel_htrans", 64'({sel, htrans}), 64'd0);
        chk("rd_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        @(negedge hclk);
        bus_idle();
        @(negedge hclk);
        hresetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge hclk);
            chk("rd_no_rsp", 64'({rsp_valid, hreq}), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1);
    end

endmodule
